// File: rtl/lidar_codec_pkg.sv
// rtl/lidar_codec_pkg.sv - shared LiDAR codec constants, frame layout and writer state type
package lidar_codec_pkg;

    localparam int N_POINTS          = 4;
    localparam int SYMBOLS_PER_POINT = 6;
    localparam int SYMBOL_WIDTH      = 16;
    localparam int FRAME_WIDTH       = 512;
    localparam int PAYLOAD_WIDTH     = N_POINTS * SYMBOLS_PER_POINT * SYMBOL_WIDTH;

    // Frame field offsets
    localparam int PAYLOAD_LSB = 0;
    localparam int COUNT_LSB   = 384;
    localparam int SIZE_LSB    = 400;
    localparam int SIZE_WIDTH  = 10;
    localparam int CRC_LSB     = 496;

    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] MODE_DELTA = 16'h0000;
    localparam logic [15:0] MODE_RAW   = 16'h0001;

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_SER,
        ST_PAD,
        ST_HDR,
        ST_OUT
    } writer_state_t;

endpackage

// File: rtl/lidar_bitstream_writer_if.sv
// rtl/lidar_bitstream_writer_if.sv - point input and frame output handshake bundle
interface lidar_bitstream_writer_if;
    import lidar_codec_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [15:0]      in_x;
    logic signed [15:0]      in_y;
    logic signed [15:0]      in_z;
    logic [31:0]             in_attr;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [FRAME_WIDTH-1:0]  compressed_data;

    // Point source / frame sink side
    modport master (
        output in_valid, in_x, in_y, in_z, in_attr, flush, out_ready,
        input  in_ready, out_valid, compressed_data
    );

    // Writer side
    modport slave (
        input  in_valid, in_x, in_y, in_z, in_attr, flush, out_ready,
        output in_ready, out_valid, compressed_data
    );

endinterface

// File: rtl/crc16_word.sv
// rtl/crc16_word.sv - combinational CRC-16-CCITT update over one 16-bit word, MSB first
module crc16_word
    import lidar_codec_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data_word,
    output logic [15:0] crc_out
);

    // Shift the word in one bit at a time, most significant bit first
    always_comb begin
        crc_out = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (crc_out[15] ^ data_word[i]) begin
                crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_out = {crc_out[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lidar_bitstream_writer.sv
// rtl/lidar_bitstream_writer.sv - delta-predicts points into symbols and packs 4-point CRC frames
module lidar_bitstream_writer
    import lidar_codec_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    lidar_bitstream_writer_if.slave  bus,
    output logic [15:0]              raw_mode_count
);

    writer_state_t             state;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [FRAME_WIDTH-1:0]    frame_q;
    logic [PAYLOAD_WIDTH-1:0]  payload;
    logic [15:0]               crc;
    logic [2:0]                pt_cnt;
    logic [4:0]                widx;
    logic [2:0]                sub;
    logic [95:0]               pt_syms;
    logic [15:0]               prev_x, prev_y, prev_z;
    logic                      flush_pend;

    logic [16:0]               res_x, res_y, res_z;
    logic                      fits;
    logic [95:0]               point_syms;
    logic [15:0]               crc_word;
    logic [15:0]               crc_next;
    logic [15:0]               point_count;
    logic [SIZE_WIDTH-1:0]     data_size;
    logic [FRAME_WIDTH-1:0]    frame_next;

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.compressed_data = frame_q;

    assign point_count = {13'b0, pt_cnt};
    assign data_size   = 10'(pt_cnt) * 10'd96;

    // Residuals in 17 bits; a point is sent raw if any residual overflows 16 bits
    always_comb begin
        res_x = {bus.in_x[15], bus.in_x} - {prev_x[15], prev_x};
        res_y = {bus.in_y[15], bus.in_y} - {prev_y[15], prev_y};
        res_z = {bus.in_z[15], bus.in_z} - {prev_z[15], prev_z};
        fits  = (res_x[16] == res_x[15]) && (res_y[16] == res_y[15]) && (res_z[16] == res_z[15]);
        if (fits) begin
            point_syms = {bus.in_attr, res_z[15:0], res_y[15:0], res_x[15:0], MODE_DELTA};
        end else begin
            point_syms = {bus.in_attr, bus.in_z, bus.in_y, bus.in_x, MODE_RAW};
        end
    end

    // Word fed to the CRC this cycle: point symbol, padding zero, or header field
    always_comb begin
        crc_word = 16'h0000;
        case (state)
            ST_SER:  crc_word = pt_syms[{sub, 4'b0000} +: SYMBOL_WIDTH];
            ST_HDR:  crc_word = (sub == 3'd0) ? point_count : {6'b0, data_size};
            default: crc_word = 16'h0000;
        endcase
    end

    crc16_word u_crc (
        .crc_in    (crc),
        .data_word (crc_word),
        .crc_out   (crc_next)
    );

    // Final frame image, captured on the last header cycle
    always_comb begin
        frame_next = '0;
        frame_next[PAYLOAD_LSB +: PAYLOAD_WIDTH] = payload;
        frame_next[COUNT_LSB +: 16]              = point_count;
        frame_next[SIZE_LSB +: SIZE_WIDTH]       = data_size;
        frame_next[CRC_LSB +: 16]                = crc_next;
    end

    // Frame assembly state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_ACCEPT;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            frame_q        <= '0;
            payload        <= '0;
            crc            <= CRC_INIT;
            pt_cnt         <= 3'd0;
            widx           <= 5'd0;
            sub            <= 3'd0;
            pt_syms        <= '0;
            prev_x         <= 16'd0;
            prev_y         <= 16'd0;
            prev_z         <= 16'd0;
            flush_pend     <= 1'b0;
            raw_mode_count <= 16'd0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        pt_syms    <= point_syms;
                        prev_x     <= bus.in_x;
                        prev_y     <= bus.in_y;
                        prev_z     <= bus.in_z;
                        flush_pend <= bus.flush;
                        sub        <= 3'd0;
                        in_ready_q <= 1'b0;
                        state      <= ST_SER;
                        if (!fits && raw_mode_count != 16'hFFFF) begin
                            raw_mode_count <= raw_mode_count + 16'd1;
                        end
                    end else if (bus.flush && pt_cnt != 3'd0) begin
                        in_ready_q <= 1'b0;
                        state      <= ST_PAD;
                    end
                end
                ST_SER: begin
                    payload[{widx, 4'b0000} +: SYMBOL_WIDTH] <= crc_word;
                    crc  <= crc_next;
                    widx <= widx + 5'd1;
                    sub  <= sub + 3'd1;
                    if (sub == 3'(SYMBOLS_PER_POINT - 1)) begin
                        pt_cnt     <= pt_cnt + 3'd1;
                        sub        <= 3'd0;
                        flush_pend <= 1'b0;
                        if (pt_cnt == 3'(N_POINTS - 1)) begin
                            state <= ST_HDR;
                        end else if (flush_pend) begin
                            state <= ST_PAD;
                        end else begin
                            in_ready_q <= 1'b1;
                            state      <= ST_ACCEPT;
                        end
                    end
                end
                ST_PAD: begin
                    crc  <= crc_next;
                    widx <= widx + 5'd1;
                    if (widx == 5'(N_POINTS * SYMBOLS_PER_POINT - 1)) begin
                        sub   <= 3'd0;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    crc <= crc_next;
                    sub <= sub + 3'd1;
                    if (sub == 3'd1) begin
                        frame_q     <= frame_next;
                        out_valid_q <= 1'b1;
                        sub         <= 3'd0;
                        state       <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        frame_q     <= '0;
                        payload     <= '0;
                        crc         <= CRC_INIT;
                        pt_cnt      <= 3'd0;
                        widx        <= 5'd0;
                        prev_x      <= 16'd0;
                        prev_y      <= 16'd0;
                        prev_z      <= 16'd0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_ACCEPT;
                    end
                end
                default: begin
                    state <= ST_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: doc/lidar_bitstream_writer.md
# lidar_bitstream_writer

Encoder-side counterpart of the LiDAR decoder path. Accepts reconstructed points (x, y, z, 32-bit attribute) one at a time, forms six 16-bit symbols per point with delta geometry prediction, and packs a batch of up to four points into one 512-bit frame. Each frame carries a header and a CRC-16. Sits between the point-cloud source and the compressed-link transmitter; its frames are exactly what the decoder's bitstream reader consumes.

## Interface
- N_POINTS, 4: points per frame
- SYMBOL_WIDTH, 16: symbol width in bits
- SYMBOLS_PER_POINT, 6: symbols per point (mode, res_x, res_y, res_z, attr_lo, attr_hi)
- CRC_INIT, 16'hFFFF: CRC-16-CCITT seed (poly 16'h1021)

Ports:
- clk  in  1  sole clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  point present
- in_ready  out  1  point accepted when in_valid && in_ready
- in_x, in_y, in_z  in  16 each  signed coordinates
- in_attr  in  32  {intensity, B, G, R}
- flush  in  1  close a partial frame
- out_valid  out  1  frame present
- out_ready  in  1  frame consumed when out_valid && out_ready
- compressed_data  out  512  frame
- raw_mode_count  out  16  points sent in raw mode since reset; saturates

## Operation
- Frame layout:
  - [16*i +: 16] holds symbol i, for i = 0..23
  - [399:384] point_count
  - [409:400] data_size, equal to 96*point_count
  - [495:410] zero
  - [511:496] CRC
- CRC coverage:
  - MSB-first, 16 bits per update.
  - Word order: symbols 0..23 (padding included), then point_count, then {6'b0, data_size}.
- Prediction:
  - prev_x, prev_y and prev_z clear to 0 at each frame start.
  - Residual = in - prev, computed in 17 bits.
  - If all three residuals fit in signed 16 bits: mode = 16'h0000 and the residuals are sent.
  - Otherwise: mode = 16'h0001, the raw coordinates are sent, and raw_mode_count increments.
  - prev is updated to the input point in both cases.
- Attribute symbols: attr_lo = in_attr[15:0], attr_hi = in_attr[31:16].
- States:
  - ACCEPT
    - in_ready = 1.
    - On a handshake: latch the point, then go to SER.
    - Else if flush and pt_cnt > 0: go to PAD.
    - Flush with pt_cnt == 0 is ignored.
  - SER
    - Writes one symbol per cycle for 6 cycles, each also updating the CRC.
    - Then pt_cnt++.
    - Go to HDR if pt_cnt reaches N_POINTS, else back to ACCEPT.
    - A flush latched during the accept cycle is held pending. After SER it goes to PAD if pt_cnt < 4, or to HDR.
  - PAD: writes zero symbols and updates the CRC, 6*(4 - pt_cnt) cycles, then HDR.
  - HDR: two CRC updates (point_count, then data_size), then OUT.
  - OUT
    - out_valid = 1 and compressed_data is held stable.
    - On a handshake: clear the frame buffer, CRC, pt_cnt and prev, then go to ACCEPT.
- in_ready = 0 in every state except ACCEPT.

## Timing
- Reset values: in_ready 0 during reset, then 1 the cycle after reset deasserts (ACCEPT). out_valid 0, compressed_data 0, raw_mode_count 0.
- Per point: 1 accept cycle plus 6 SER cycles, so at most one point per 7 cycles.
- 4th point accepted at edge T: out_valid rises after edge T+8 (6 SER + 2 HDR).
- Flush with k points: extra 6*(4-k) PAD cycles before HDR.
- OUT handshake at edge T: in_ready = 1 from T+1. No back-to-back overlap.
- Reset mid-frame or while in OUT: the frame is discarded with no partial output. The CRC and prev reinitialise.
- raw_mode_count saturates at 16'hFFFF.

## Structure
- Shared package lidar_codec_pkg holds:
  - N_POINTS, SYMBOLS_PER_POINT, SYMBOL_WIDTH
  - frame field offsets: PAYLOAD_LSB, COUNT_LSB, SIZE_LSB, CRC_LSB
  - CRC_POLY, CRC_INIT
  - mode codes MODE_DELTA and MODE_RAW
  - the writer state enum
- The decoder side imports the same package.
- Sub-module crc16_word: combinational next_crc(crc, word16). It is reused by the reader-side checker.

## Test plan
- Points (10,20,30), (12,18,35), (12,18,35), (0,0,0), attr 32'h11223344 each → symbols:
  - {0,10,20,30,3344,1122}
  - {0,2,-2,5,...}
  - {0,0,0,0,...}
  - {0,-12,-18,-35,...}
  - point_count = 4, data_size = 384, CRC equal to the model value; out_valid exactly 8 cycles after the 4th accept.
- Points (-32768,0,0) then (32767,0,0) → second point mode = 1 with raw symbols 7FFF,0,0; raw_mode_count = 1.
- 2 points then flush → symbols 12..23 zero, point_count = 2, data_size = 192, CRC over the padded payload.
- out_ready held low for 20 cycles → compressed_data stable, in_ready = 0, in_valid ignored; handshake → in_ready = 1 the next cycle.
- Reset asserted during SER of the 3rd point → out_valid stays 0. A following 4-point frame matches a fresh-start model (prev = 0, CRC seed FFFF).
- Flush asserted with 0 points, and flush coincident with the 4th point accept → no frame in the first case; exactly one full frame with no padding in the second.
